// File: rtl/axis_rr_arbiter_mux.sv
// Round-robin AXI4-Stream arbiter/mux with packet-level grants and a registered output stage.
// One arbitration cycle per packet; the granted source is held until its tlast beat is accepted.
module axis_rr_arbiter_mux #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int LAST_ENABLE = 1,
    parameter int SEL_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [SEL_WIDTH-1:0]          grant_index
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SEL_WIDTH-1:0]   last_grant;
    logic [SEL_WIDTH-1:0]   pick_index;
    logic [SEL_WIDTH-1:0]   low_above;
    logic [SEL_WIDTH-1:0]   low_all;
    logic                   found_above;
    logic                   pick_found;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [USER_WIDTH-1:0]  sel_user;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   out_free;
    logic                   accept;
    logic                   release_grant;

    // Rotating priority: lowest valid index above last_grant wins, otherwise wrap to the lowest valid index.
    always_comb begin
        low_above   = '0;
        low_all     = '0;
        found_above = 1'b0;
        pick_found  = 1'b0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                pick_found = 1'b1;
                low_all    = SEL_WIDTH'(i);
                if (SEL_WIDTH'(i) > last_grant) begin
                    found_above = 1'b1;
                    low_above   = SEL_WIDTH'(i);
                end
            end
        end
        pick_index = found_above ? low_above : low_all;
    end

    always_comb begin
        sel_data  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index == SEL_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_last  = s_axis_tlast[i];
                sel_valid = s_axis_tvalid[i];
            end
        end
    end

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign accept        = (state == ACTIVE) && sel_valid && out_free;
    assign release_grant = accept && (sel_last || (LAST_ENABLE == 0));

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if ((state == ACTIVE) && (grant_index == SEL_WIDTH'(i))) begin
                s_axis_tready[i] = out_free;
            end
        end
    end

    // Output register loads on accept; a drain without a new beat empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= SEL_WIDTH'(S_COUNT - 1);
            grant_index   <= '0;
            grant_valid   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= (LAST_ENABLE != 0) ? sel_last : 1'b1;
                m_axis_tuser  <= (USER_ENABLE != 0) ? sel_user : '0;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_index <= pick_index;
                        last_grant  <= pick_index;
                        grant_valid <= 1'b1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (release_grant) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter_mux.sv
// Bench for axis_rr_arbiter_mux: packet-level reference model checked every cycle,
// plus directed scenarios pinned with hand-computed beat and grant orders.
module tb_axis_rr_arbiter_mux;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int UW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [S*DW-1:0] s_axis_tdata;
    logic [S-1:0]    s_axis_tvalid;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast;
    logic [S*UW-1:0] s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [UW-1:0]   m_axis_tuser;
    logic            grant_valid;
    logic [1:0]      grant_index;

    logic [15:0]     nl_tdata = 16'h6050;
    logic [1:0]      nl_tvalid = 2'b11;
    logic [1:0]      nl_tready;
    logic [1:0]      nl_tlast = 2'b00;
    logic [1:0]      nl_tuser = 2'b00;
    logic [7:0]      nl_m_tdata;
    logic            nl_m_tvalid;
    logic            nl_m_tready = 1'b1;
    logic            nl_m_tlast;
    logic [0:0]      nl_m_tuser;
    logic            nl_grant_valid;
    logic [0:0]      nl_grant_index;

    int tests_run    = 0;
    int tests_failed = 0;
    logic check_en   = 1'b0;

    logic [7:0] src_mem   [S][32];
    logic       src_lastm [S][32];
    logic       src_userm [S][32];
    int         src_len   [S];
    int         src_pos   [S];
    logic [S-1:0] stall;

    logic [7:0] out_log[$];
    logic       last_log[$];
    int         nl_log[$];
    int         nl_glog[$];

    int         mdl_owner;
    int         mdl_prio;
    logic       mdl_ov;
    logic [7:0] mdl_od;
    logic       mdl_ol;
    logic       mdl_ou;

    always #5 clk = ~clk;

    axis_rr_arbiter_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_ENABLE(1), .USER_WIDTH(UW), .LAST_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    axis_rr_arbiter_mux #(.S_COUNT(2), .DATA_WIDTH(8), .USER_ENABLE(1), .USER_WIDTH(1), .LAST_ENABLE(0)) dut_nl (
        .clk(clk), .rst(rst),
        .s_axis_tdata(nl_tdata), .s_axis_tvalid(nl_tvalid), .s_axis_tready(nl_tready),
        .s_axis_tlast(nl_tlast), .s_axis_tuser(nl_tuser),
        .m_axis_tdata(nl_m_tdata), .m_axis_tvalid(nl_m_tvalid), .m_axis_tready(nl_m_tready),
        .m_axis_tlast(nl_m_tlast), .m_axis_tuser(nl_m_tuser),
        .grant_valid(nl_grant_valid), .grant_index(nl_grant_index)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [7:0] data, input logic last, input logic user);
        src_mem[port][src_len[port] % 32]   = data;
        src_lastm[port][src_len[port] % 32] = last;
        src_userm[port][src_len[port] % 32] = user;
        src_len[port]++;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected ready: only the current packet owner, and only when the output slot can take a beat.
    function automatic logic [S-1:0] model_ready();
        logic [S-1:0] r;
        r = '0;
        if (mdl_owner >= 0) r[mdl_owner] = !mdl_ov || m_axis_tready;
        return r;
    endfunction

    // Source drivers: each port walks its beat list, advancing on a handshake seen just before the edge.
    initial begin
        logic [S-1:0] hs;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        for (int i = 0; i < S; i++) src_pos[i] = 0;
        forever begin
            @(negedge clk);
            #4;
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < S; i++) begin
                if (hs[i]) src_pos[i]++;
                s_axis_tvalid[i]        = !stall[i] && (src_pos[i] < src_len[i]);
                s_axis_tdata[i*DW +: DW] = src_mem[i][src_pos[i] % 32];
                s_axis_tlast[i]         = src_lastm[i][src_pos[i] % 32];
                s_axis_tuser[i]         = src_userm[i][src_pos[i] % 32];
            end
        end
    end

    // Reference model: owner / rotating priority / one-slot output buffer.
    always @(posedge clk) begin
        logic [S-1:0] rdy;
        logic acc;
        if (rst) begin
            mdl_owner = -1;
            mdl_prio  = S - 1;
            mdl_ov    = 1'b0;
            mdl_od    = '0;
            mdl_ol    = 1'b0;
            mdl_ou    = 1'b0;
        end else begin
            rdy = model_ready();
            acc = (mdl_owner >= 0) && s_axis_tvalid[mdl_owner] && rdy[mdl_owner];
            if (acc) begin
                mdl_ov = 1'b1;
                mdl_od = s_axis_tdata[mdl_owner*DW +: DW];
                mdl_ol = s_axis_tlast[mdl_owner];
                mdl_ou = s_axis_tuser[mdl_owner];
            end else if (m_axis_tready) begin
                mdl_ov = 1'b0;
            end
            if (mdl_owner < 0) begin
                for (int k = 1; k <= S; k++) begin
                    if (mdl_owner < 0 && s_axis_tvalid[(mdl_prio + k) % S]) begin
                        mdl_owner = (mdl_prio + k) % S;
                        mdl_prio  = mdl_owner;
                    end
                end
            end else if (acc && s_axis_tlast[mdl_owner]) begin
                mdl_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            checkOutput("s_tready", 32'(s_axis_tready), 32'(model_ready()));
            checkOutput("m_tvalid", 32'(m_axis_tvalid), 32'(mdl_ov));
            checkOutput("grant_valid", 32'(grant_valid), 32'(mdl_owner >= 0));
            if (mdl_owner >= 0) checkOutput("grant_index", 32'(grant_index), 32'(mdl_owner));
            if (mdl_ov) begin
                checkOutput("m_tdata", 32'(m_axis_tdata), 32'(mdl_od));
                checkOutput("m_tlast", 32'(m_axis_tlast), 32'(mdl_ol));
                checkOutput("m_tuser", 32'(m_axis_tuser), 32'(mdl_ou));
            end
        end
    end

    // Output beat loggers, sampled just before the edge that completes the transfer.
    always @(negedge clk) begin
        #4;
        if (check_en && !rst && m_axis_tvalid && m_axis_tready) begin
            out_log.push_back(m_axis_tdata);
            last_log.push_back(m_axis_tlast);
        end
    end

    always @(negedge clk) begin
        logic prev_gv;
        #4;
        if (check_en && !rst) begin
            if (nl_m_tvalid && nl_m_tready && nl_log.size() < 4) nl_log.push_back(int'(nl_m_tdata));
            if (nl_grant_valid && !prev_gv && nl_glog.size() < 4) nl_glog.push_back(int'(nl_grant_index));
        end
        prev_gv = nl_grant_valid;
    end

    initial begin
        int mark;
        logic [7:0] exp_fair [6];
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        stall         = '0;
        for (int i = 0; i < S; i++) src_len[i] = 0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        check_en = 1'b1;
        #3;
        checkOutput("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("reset_grant_valid", 32'(grant_valid), 32'd0);
        checkOutput("reset_s_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("reset_m_tdata", 32'(m_axis_tdata), 32'd0);

        // Single source, 3-beat packet from port 2.
        applyReset();
        mark = out_log.size();
        applyStimulus(2, 8'h11, 1'b0, 1'b1);
        applyStimulus(2, 8'h22, 1'b0, 1'b0);
        applyStimulus(2, 8'h33, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("t1_grant_valid", 32'(grant_valid), 32'd1);
        checkOutput("t1_grant_index", 32'(grant_index), 32'd2);
        repeat (8) @(negedge clk);
        checkOutput("t1_count", 32'(out_log.size() - mark), 32'd3);
        if (out_log.size() >= mark + 3) begin
            checkOutput("t1_beat0", 32'(out_log[mark]), 32'h11);
            checkOutput("t1_beat1", 32'(out_log[mark+1]), 32'h22);
            checkOutput("t1_beat2", 32'(out_log[mark+2]), 32'h33);
            checkOutput("t1_last01", 32'({last_log[mark], last_log[mark+1]}), 32'd0);
            checkOutput("t1_last2", 32'(last_log[mark+2]), 32'd1);
        end
        checkOutput("t1_grant_dropped", 32'(grant_valid), 32'd0);

        // Fairness with all ports requesting 1-beat packets.
        applyReset();
        mark = out_log.size();
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < S; p++) applyStimulus(p, 8'hA0 + 8'(p), 1'b1, 1'(p));
        repeat (20) @(negedge clk);
        exp_fair = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
        checkOutput("t2_count", 32'(out_log.size() - mark), 32'd8);
        for (int k = 0; k < 6; k++)
            if (out_log.size() > mark + k) checkOutput("t2_order", 32'(out_log[mark+k]), 32'(exp_fair[k]));

        // Backpressure during a 4-beat packet from port 1.
        applyReset();
        mark = out_log.size();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(1, 8'h31 + 8'(k), 1'(k == 3), 1'b0);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("t3_hold_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("t3_hold_data", 32'(m_axis_tdata), 32'h31);
        checkOutput("t3_hold_ready", 32'(s_axis_tready), 32'd0);
        repeat (5) @(negedge clk);
        #3;
        checkOutput("t3_still_data", 32'(m_axis_tdata), 32'h31);
        @(negedge clk);
        m_axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t3_count", 32'(out_log.size() - mark), 32'd4);
        for (int k = 0; k < 4; k++)
            if (out_log.size() > mark + k) checkOutput("t3_order", 32'(out_log[mark+k]), 32'h31 + 32'(k));

        // Port 3 stalls mid-packet while port 0 waits.
        applyReset();
        mark = out_log.size();
        applyStimulus(3, 8'h41, 1'b0, 1'b0);
        applyStimulus(3, 8'h42, 1'b0, 1'b0);
        applyStimulus(3, 8'h43, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        stall[3] = 1'b1;
        applyStimulus(0, 8'h0F, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #3;
            checkOutput("t4_grant_index", 32'(grant_index), 32'd3);
            checkOutput("t4_port0_ready", 32'(s_axis_tready[0]), 32'd0);
        end
        stall[3] = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t4_count", 32'(out_log.size() - mark), 32'd4);
        if (out_log.size() >= mark + 4) begin
            checkOutput("t4_beat2", 32'(out_log[mark+2]), 32'h43);
            checkOutput("t4_beat3", 32'(out_log[mark+3]), 32'h0F);
        end

        // LAST_ENABLE=0 instance: grants alternate every beat.
        checkOutput("t5_nl_count", 32'(nl_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (nl_log.size() > k) checkOutput("t5_nl_data", 32'(nl_log[k]), (k % 2 == 0) ? 32'h50 : 32'h60);
            if (nl_glog.size() > k) checkOutput("t5_nl_grant", 32'(nl_glog[k]), 32'(k % 2));
        end

        // Reset in the middle of a port-2 packet, port 1 also requesting.
        applyReset();
        for (int k = 0; k < 4; k++) applyStimulus(2, 8'h61 + 8'(k), 1'(k == 3), 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1, 8'h71, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mark = out_log.size();
        #3;
        checkOutput("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t6_grant_valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        #3;
        checkOutput("t6_regrant_valid", 32'(grant_valid), 32'd1);
        checkOutput("t6_regrant_index", 32'(grant_index), 32'd1);
        repeat (12) @(negedge clk);
        checkOutput("t6_count", 32'(out_log.size() - mark), 32'd3);
        if (out_log.size() >= mark + 3) begin
            checkOutput("t6_beat0", 32'(out_log[mark]), 32'h71);
            checkOutput("t6_beat1", 32'(out_log[mark+1]), 32'h63);
            checkOutput("t6_beat2", 32'(out_log[mark+2]), 32'h64);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
